caravel_adder: RTL and testbench

CARAVEL_ADDER -- requirements
Module: caravel_adder

---
 rtl/caravel_adder_pkg.sv | 35 +++
 rtl/caravel_adder_spi_flash_reader.sv | 129 ++++++++++++
 rtl/caravel_adder.sv | 145 ++++++++++++++
 tb/tb_caravel_adder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/caravel_adder_pkg.sv
// caravel_adder_pkg
//   Shared definitions for the flash-driven adder self-test: FSM state
//   encoding, SPI read opcode, operand record geometry and the status
//   codes presented on mprj_io[31:16].
package caravel_adder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        CHECK,
        PASS,
        FAIL
    } state_e;

    localparam logic [7:0]  READ_OPCODE  = 8'h03;
    localparam int unsigned RECORD_BYTES = 12;
    localparam int unsigned CMD_BITS     = 32;
    localparam int unsigned TOTAL_PULSES = CMD_BITS + 8 * RECORD_BYTES;

    localparam logic [15:0] STATUS_IDLE = 16'h0000;
    localparam logic [15:0] STATUS_BUSY = 16'hAB60;
    localparam logic [15:0] STATUS_PASS = 16'hAB61;
    localparam logic [15:0] STATUS_FAIL = 16'hAB6F;

    // 32-bit sum with the carry dropped, compared against the expected word.
    function automatic logic sum_matches(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] expected);
        logic [31:0] sum;
        sum = a + b;
        return sum == expected;
    endfunction

endpackage

// File: rtl/caravel_adder_spi_flash_reader.sv
// spi_flash_reader
//   Issues a single SPI READ (opcode + 24-bit address) and then clocks in
//   RECORD_BYTES bytes, presenting each with a one-cycle byte_valid strobe.
//   Ports:
//     clk_i, rst_ni      system clock, async active-low reset
//     start_i            begin a read (ignored while busy)
//     csb_o/sck_o/mosi_o SPI chip select, clock (idle low), MOSI
//     miso_i             SPI MISO, sampled on rising sck
//     cmd_done_o         strobe: command/address phase finished
//     byte_valid_o       strobe: byte_o holds a received byte
//     byte_o             received byte, MSB first on the wire
//     done_o             strobe: last byte received, csb released
module spi_flash_reader
    import caravel_adder_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int unsigned SCK_DIV    = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    output logic       csb_o,
    output logic       sck_o,
    output logic       mosi_o,
    input  logic       miso_i,
    output logic       cmd_done_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       done_o
);

    localparam int unsigned HALF    = SCK_DIV / 2;
    localparam int unsigned DIV_W   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned PULSE_W = $clog2(TOTAL_PULSES);

    localparam logic [DIV_W-1:0]   DIV_LAST       = DIV_W'(HALF - 1);
    localparam logic [PULSE_W-1:0] LAST_PULSE     = PULSE_W'(TOTAL_PULSES - 1);
    localparam logic [PULSE_W-1:0] LAST_CMD_PULSE = PULSE_W'(CMD_BITS - 1);
    localparam logic [PULSE_W-1:0] FIRST_DATA     = PULSE_W'(CMD_BITS);

    logic               busy_q;
    logic [DIV_W-1:0]   div_q;
    logic [PULSE_W-1:0] pulse_q;
    logic [31:0]        tx_q;
    logic [7:0]         rx_q;
    logic               csb_q;
    logic               sck_q;
    logic               mosi_q;
    logic               cmd_done_q;
    logic               byte_valid_q;
    logic [7:0]         byte_q;
    logic               done_q;

    logic tick;
    logic in_data;

    assign tick    = busy_q && (div_q == DIV_LAST);
    assign in_data = (pulse_q >= FIRST_DATA);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q       <= 1'b0;
            div_q        <= '0;
            pulse_q      <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            csb_q        <= 1'b1;
            sck_q        <= 1'b0;
            mosi_q       <= 1'b0;
            cmd_done_q   <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            cmd_done_q   <= 1'b0;
            byte_valid_q <= 1'b0;
            done_q       <= 1'b0;
            if (start_i && !busy_q) begin
                // First command bit is set up before the first rising sck;
                // the remaining 31 bits wait in tx_q for falling edges.
                busy_q  <= 1'b1;
                csb_q   <= 1'b0;
                sck_q   <= 1'b0;
                div_q   <= '0;
                pulse_q <= '0;
                mosi_q  <= READ_OPCODE[7];
                tx_q    <= {READ_OPCODE[6:0], FLASH_BASE, 1'b0};
            end else if (busy_q) begin
                div_q <= tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    sck_q <= ~sck_q;
                    if (!sck_q) begin
                        // Rising sck: flash data is stable, capture it.
                        if (in_data) begin
                            rx_q <= {rx_q[6:0], miso_i};
                        end
                    end else begin
                        // Falling sck: one pulse complete, advance MOSI.
                        pulse_q <= pulse_q + 1'b1;
                        mosi_q  <= tx_q[31];
                        tx_q    <= {tx_q[30:0], 1'b0};
                        if (pulse_q == LAST_CMD_PULSE) begin
                            cmd_done_q <= 1'b1;
                        end
                        if (in_data && (pulse_q[2:0] == 3'b111)) begin
                            byte_valid_q <= 1'b1;
                            byte_q       <= rx_q;
                        end
                        if (pulse_q == LAST_PULSE) begin
                            busy_q <= 1'b0;
                            csb_q  <= 1'b1;
                            mosi_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign csb_o        = csb_q;
    assign sck_o        = sck_q;
    assign mosi_o       = mosi_q;
    assign cmd_done_o   = cmd_done_q;
    assign byte_valid_o = byte_valid_q;
    assign byte_o       = byte_q;
    assign done_o       = done_q;

endmodule

// File: rtl/caravel_adder.sv
// caravel_adder
//   Self-test user project: reads an operand record (A, B, EXP, each 32-bit
//   little-endian) from SPI flash, checks (A + B) mod 2^32 == EXP and
//   reports the verdict.
//   Ports:
//     clock, resetb           system clock, async active-low reset
//     mprj_io[31:16]          status word (AB60 busy, AB61 pass, AB6F fail)
//     mprj_io[3]              sampled input, no function; others high-Z
//     gpio                    1 when the check passed, else 0
//     flash_csb/clk/io0/io1   SPI flash interface
//     vddio ... vssd2         power pins, no logic function
module caravel_adder
    import caravel_adder_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int unsigned SCK_DIV    = 2
) (
    input  logic        vddio,
    input  logic        vddio_2,
    input  logic        vssio,
    input  logic        vssio_2,
    input  logic        vdda,
    input  logic        vssa,
    input  logic        vccd,
    input  logic        vssd,
    input  logic        vdda1,
    input  logic        vdda1_2,
    input  logic        vdda2,
    input  logic        vssa1,
    input  logic        vssa1_2,
    input  logic        vssa2,
    input  logic        vccd1,
    input  logic        vccd2,
    input  logic        vssd1,
    input  logic        vssd2,
    input  logic        clock,
    input  logic        resetb,
    inout  wire  [37:0] mprj_io,
    inout  wire         gpio,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    state_e      state_q;
    logic [3:0]  byte_cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] exp_q;
    logic [15:0] status_q;
    logic        gpio_q;
    logic        unused_io3_q;

    logic       rd_start;
    logic       rd_cmd_done;
    logic       rd_byte_valid;
    logic [7:0] rd_byte;
    logic       rd_done;

    assign rd_start = (state_q == IDLE);

    spi_flash_reader #(
        .FLASH_BASE(FLASH_BASE),
        .SCK_DIV   (SCK_DIV)
    ) u_reader (
        .clk_i       (clock),
        .rst_ni      (resetb),
        .start_i     (rd_start),
        .csb_o       (flash_csb),
        .sck_o       (flash_clk),
        .mosi_o      (flash_io0),
        .miso_i      (flash_io1),
        .cmd_done_o  (rd_cmd_done),
        .byte_valid_o(rd_byte_valid),
        .byte_o      (rd_byte),
        .done_o      (rd_done)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            a_q          <= '0;
            b_q          <= '0;
            exp_q        <= '0;
            status_q     <= STATUS_IDLE;
            gpio_q       <= 1'b0;
            unused_io3_q <= 1'b0;
        end else begin
            unused_io3_q <= mprj_io[3];

            // Byte n lands in word n/4 at lane n%4 (little-endian record).
            if (rd_byte_valid) begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
                case (byte_cnt_q[3:2])
                    2'd0:    a_q[{byte_cnt_q[1:0], 3'b000} +: 8]   <= rd_byte;
                    2'd1:    b_q[{byte_cnt_q[1:0], 3'b000} +: 8]   <= rd_byte;
                    default: exp_q[{byte_cnt_q[1:0], 3'b000} +: 8] <= rd_byte;
                endcase
            end

            case (state_q)
                IDLE: begin
                    state_q  <= CMD;
                    status_q <= STATUS_BUSY;
                end
                CMD: begin
                    if (rd_cmd_done) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (rd_done) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (sum_matches(a_q, b_q, exp_q)) begin
                        state_q  <= PASS;
                        status_q <= STATUS_PASS;
                        gpio_q   <= 1'b1;
                    end else begin
                        state_q  <= FAIL;
                        status_q <= STATUS_FAIL;
                        gpio_q   <= 1'b0;
                    end
                end
                PASS:    state_q <= PASS;
                FAIL:    state_q <= FAIL;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mprj_io = {6'bz, status_q, 16'bz};
    assign gpio    = gpio_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, vddio, vddio_2, vssio, vssio_2, vdda, vssa,
                         vccd, vssd, vdda1, vdda1_2, vdda2, vssa1, vssa1_2,
                         vssa2, vccd1, vccd2, vssd1, vssd2, unused_io3_q,
                         mprj_io, gpio};

endmodule

// File: tb/tb_caravel_adder.sv
module tb_caravel_adder;

    localparam logic [31:0] EXP_CMD   = {8'h03, 24'h000000};
    localparam int unsigned LAT_LIMIT = 260;
    localparam int unsigned TIMEOUT   = 70000;

    logic       clock;
    logic       resetb;
    logic       io3_drv;
    logic       flash_csb;
    logic       flash_clk;
    logic       flash_io0;
    logic       flash_io1;
    wire [37:0] mprj_io;
    wire        gpio;

    assign mprj_io[3] = io3_drv;

    caravel_adder dut (
        .vddio(1'b1), .vddio_2(1'b1), .vssio(1'b0), .vssio_2(1'b0),
        .vdda(1'b1), .vssa(1'b0), .vccd(1'b1), .vssd(1'b0),
        .vdda1(1'b1), .vdda1_2(1'b1), .vdda2(1'b1), .vssa1(1'b0),
        .vssa1_2(1'b0), .vssa2(1'b0), .vccd1(1'b1), .vccd2(1'b1),
        .vssd1(1'b0), .vssd2(1'b0),
        .clock    (clock),
        .resetb   (resetb),
        .mprj_io  (mprj_io),
        .gpio     (gpio),
        .flash_csb(flash_csb),
        .flash_clk(flash_clk),
        .flash_io0(flash_io0),
        .flash_io1(flash_io1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic chk_le(input string name, input int unsigned act, input int unsigned limit);
        n_checks++;
        if (act > limit) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected <= %0d", name, act, limit);
        end
    endtask

    // ---------------- flash model ----------------
    logic [7:0]  rec [12];
    int unsigned pulses      = 0;
    int unsigned last_pulses = 0;
    logic [31:0] cmd_word    = '0;

    initial flash_io1 = 1'b0;

    always @(negedge flash_csb) begin
        pulses   = 0;
        cmd_word = '0;
    end

    always @(posedge flash_csb) last_pulses = pulses;

    always @(posedge flash_clk) begin
        if (!flash_csb) begin
            if (pulses < 32) cmd_word = {cmd_word[30:0], flash_io0};
            pulses++;
        end
    end

    always @(negedge flash_clk) begin
        int unsigned k;
        if (!flash_csb && pulses >= 32 && pulses < 128) begin
            k = pulses - 32;
            flash_io1 = rec[k / 8][7 - (k % 8)];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        pass;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } exp_t;

    exp_t sb[$];

    int unsigned cyc      = 0;
    int unsigned last_cyc = 0;
    bit          saw60    = 0;
    bit          saw_bad  = 0;
    bit          reported = 0;
    int          done_cnt = 0;

    always @(negedge clock) begin
        logic [15:0] st;
        exp_t        ex;
        if (!resetb) begin
            cyc      = 0;
            saw60    = 0;
            saw_bad  = 0;
            reported = 0;
        end else if (!reported) begin
            cyc++;
            st = mprj_io[31:16];
            if (st == 16'hAB61 || st == 16'hAB6F) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(st), 32'h0);
                end else begin
                    ex = sb.pop_front();
                    chk("status_final", 32'(st), ex.pass ? 32'hAB61 : 32'hAB6F);
                    chk("gpio_final", 32'(gpio), 32'(ex.pass));
                    chk_le("latency", cyc, LAT_LIMIT);
                    chk("ab60_seen", 32'(saw60), 32'h1);
                    chk("no_stray_status", 32'(saw_bad), 32'h0);
                    chk("cmd_word", cmd_word, EXP_CMD);
                    chk("sck_pulses", last_pulses, 32'd128);
                    chk("csb_released", 32'(flash_csb), 32'h1);
                    chk("sck_idle", 32'(flash_clk), 32'h0);
                end
                last_cyc = cyc;
                reported = 1;
                done_cnt++;
            end else if (st == 16'hAB60) begin
                saw60 = 1;
            end else if (st != 16'h0000 || saw60) begin
                saw_bad = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic model_pass(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] e);
        longint unsigned s;
        s = longint'(a) + longint'(b);
        return (s % 64'h1_0000_0000) == longint'(e);
    endfunction

    task automatic run_case(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e, input logic io3, input bit abort);
        exp_t ex;
        int   d0;
        bit   reached;
        @(negedge clock);
        resetb  = 1'b0;
        io3_drv = io3;
        for (int j = 0; j < 4; j++) begin
            rec[j]     = a[8*j +: 8];
            rec[4 + j] = b[8*j +: 8];
            rec[8 + j] = e[8*j +: 8];
        end
        repeat (3) @(negedge clock);
        chk("rst_status", 32'(mprj_io[31:16]), 32'h0);
        chk("rst_csb", 32'(flash_csb), 32'h1);
        chk("rst_sck", 32'(flash_clk), 32'h0);
        chk("rst_io0", 32'(flash_io0), 32'h0);
        chk("rst_gpio", 32'(gpio), 32'h0);

        if (abort) begin
            resetb  = 1'b1;
            reached = 0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clock);
                if (!flash_csb && pulses >= 67) begin
                    reached = 1;
                    break;
                end
            end
            chk("abort_reached_byte5", 32'(reached), 32'h1);
            #2 resetb = 1'b0;
            #1;
            chk("abort_csb", 32'(flash_csb), 32'h1);
            chk("abort_status", 32'(mprj_io[31:16]), 32'h0);
            chk("abort_sck", 32'(flash_clk), 32'h0);
            repeat (2) @(negedge clock);
        end

        ex.pass = model_pass(a, b, e);
        ex.a = a;
        ex.b = b;
        ex.e = e;
        sb.push_back(ex);
        d0 = done_cnt;
        resetb = 1'b1;
        for (int i = 0; i < TIMEOUT && done_cnt == d0; i++) @(negedge clock);
        if (done_cnt == d0) begin
            chk("timeout", 32'h0, 32'h1);
            sb.delete();
        end
        repeat (20) @(negedge clock);
        chk("status_hold", 32'(mprj_io[31:16]), ex.pass ? 32'hAB61 : 32'hAB6F);
        chk("gpio_hold", 32'(gpio), 32'(ex.pass));
    endtask

    initial begin
        int unsigned lat_io3_0;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] re;
        resetb  = 1'b1;
        io3_drv = 1'b0;
        #1 resetb = 1'b0;

        run_case(32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 0);
        lat_io3_0 = last_cyc;
        run_case(32'h12345678, 32'h11111111, 32'h23456789, 1'b1, 0);
        chk("io3_timing", last_cyc, lat_io3_0);
        run_case(32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 0);
        run_case(32'h00000001, 32'h00000002, 32'h00000004, 1'b1, 0);
        run_case(32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1);

        for (int n = 0; n < 6; n++) begin
            ra = $urandom;
            rb = $urandom;
            re = ($urandom_range(0, 1) == 1) ? ra + rb : $urandom;
            run_case(ra, rb, re, 1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
